// File: rtl/or_arr_param_if.sv
// Bus bundle for or_arr_param: a qualified input array and registered OR-reduction results.
// The master drives the array; the slave (the reduction unit) returns the registered results.
interface or_arr_param_if #(
  parameter int unsigned WIDTH_I   = 4,
  parameter int unsigned WIDTH_I_X = 2
);
  localparam int unsigned CntW = $clog2(WIDTH_I + 1);

  logic                              in_valid;
  logic [WIDTH_I-1:0][WIDTH_I_X-1:0] in;
  logic                              out;
  logic [WIDTH_I-1:0]                elem_or;
  logic [CntW-1:0]                   nz_count;
  logic                              out_valid;

  modport master (
    output in_valid,
    output in,
    input  out,
    input  elem_or,
    input  nz_count,
    input  out_valid
  );

  modport slave (
    input  in_valid,
    input  in,
    output out,
    output elem_or,
    output nz_count,
    output out_valid
  );
endinterface

// File: rtl/or_arr_param.sv
// Registered OR-reduction of a packed 2-D array: global OR, per-element OR and a count of
// non-zero elements. Results update one cycle after each valid input and hold otherwise.
module or_arr_param #(
  parameter int unsigned WIDTH_I   = 4,
  parameter int unsigned WIDTH_I_X = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  or_arr_param_if.slave  bus
);
  localparam int unsigned CntW = $clog2(WIDTH_I + 1);

  logic [WIDTH_I-1:0] elem_d, elem_q;
  logic [CntW-1:0]    cnt_d, cnt_q;
  logic               out_d, out_q;
  logic               valid_q;

  always_comb begin
    elem_d = '0;
    cnt_d  = '0;
    for (int k = 0; k < WIDTH_I; k++) begin
      elem_d[k] = |bus.in[k];
      cnt_d     = cnt_d + CntW'(elem_d[k]);
    end
    out_d = |elem_d;
  end

  // Data registers load only on in_valid, so X on an unqualified input never reaches them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q   <= 1'b0;
      elem_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        out_q  <= out_d;
        elem_q <= elem_d;
        cnt_q  <= cnt_d;
      end
    end
  end

  assign bus.out       = out_q;
  assign bus.elem_or   = elem_q;
  assign bus.nz_count  = cnt_q;
  assign bus.out_valid = valid_q;
endmodule

// File: tb/tb_or_arr_param.sv
// Bench for or_arr_param: directed steps on the default configuration, then randomized traffic
// on three configurations checked against an element-value model.
module tb_or_arr_param;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  or_arr_param_if #(.WIDTH_I(4), .WIDTH_I_X(2)) if0 ();
  or_arr_param_if #(.WIDTH_I(1), .WIDTH_I_X(1)) if1 ();
  or_arr_param_if #(.WIDTH_I(5), .WIDTH_I_X(3)) if2 ();

  or_arr_param #(.WIDTH_I(4), .WIDTH_I_X(2)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  or_arr_param #(.WIDTH_I(1), .WIDTH_I_X(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  or_arr_param #(.WIDTH_I(5), .WIDTH_I_X(3)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic       o;
    logic [7:0] e;
    logic [7:0] c;
    logic       v;
  } res_t;

  res_t exp0, exp1, exp2;

  // Element k is non-zero when its x-bit slice of the flattened word is non-zero.
  function automatic res_t model(input logic [63:0] w, input int n, input int x, input logic vld,
                                 input res_t prev);
    res_t r;
    logic [63:0] slice;
    r = prev;
    r.v = vld;
    if (vld) begin
      r.e = '0;
      r.c = '0;
      for (int k = 0; k < n; k++) begin
        slice = (w >> (k * x)) & ((64'd1 << x) - 64'd1);
        if (slice != 0) begin
          r.e[k] = 1'b1;
          r.c    = r.c + 8'd1;
        end
      end
      r.o = (r.c != 0);
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk0(input string tag, input logic o, input logic [3:0] e, input logic [2:0] c,
                      input logic v);
    chk({tag, ".out"},       32'(if0.out),       32'(o));
    chk({tag, ".elem_or"},   32'(if0.elem_or),   32'(e));
    chk({tag, ".nz_count"},  32'(if0.nz_count),  32'(c));
    chk({tag, ".out_valid"}, 32'(if0.out_valid), 32'(v));
  endtask

  task automatic step0(input logic [7:0] d, input logic vld);
    if0.in       = d;
    if0.in_valid = vld;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [63:0] w;
    logic        vld;
    logic [7:0]  b2b [4];

    rst_n = 1'b0;
    if0.in_valid = 1'b0; if0.in = '0;
    if1.in_valid = 1'b0; if1.in = '0;
    if2.in_valid = 1'b0; if2.in = '0;
    exp0 = '0; exp1 = '0; exp2 = '0;

    repeat (2) @(posedge clk);
    #1;
    chk0("reset", 1'b0, 4'h0, 3'd0, 1'b0);
    rst_n = 1'b1;
    step0(8'h00, 1'b0);
    chk0("release", 1'b0, 4'h0, 3'd0, 1'b0);

    // {00,01,10,11}
    step0(8'h1B, 1'b1);
    chk0("v1B", 1'b1, 4'b0111, 3'd3, 1'b1);

    // Asynchronous reset mid-cycle while out=1
    #3;
    rst_n = 1'b0;
    #1;
    chk0("async_rst", 1'b0, 4'h0, 3'd0, 1'b0);
    step0(8'hFF, 1'b1);
    chk0("rst_held", 1'b0, 4'h0, 3'd0, 1'b0);
    rst_n = 1'b1;
    step0(8'hFF, 1'b0);
    chk0("rst_discard", 1'b0, 4'h0, 3'd0, 1'b0);

    step0(8'h0A, 1'b1);
    chk0("v0A", 1'b1, 4'b0011, 3'd2, 1'b1);
    step0(8'h5B, 1'b1);
    chk0("v5B", 1'b1, 4'b1111, 3'd4, 1'b1);
    step0(8'h00, 1'b1);
    chk0("v00", 1'b0, 4'b0000, 3'd0, 1'b1);
    step0(8'hFF, 1'b0);
    chk0("hold_ff", 1'b0, 4'b0000, 3'd0, 1'b0);
    step0(8'hxx, 1'b0);
    chk0("hold_x", 1'b0, 4'b0000, 3'd0, 1'b0);

    // Back-to-back: four valid inputs, four consecutive results
    b2b[0] = 8'h03; b2b[1] = 8'h40; b2b[2] = 8'h24; b2b[3] = 8'hC1;
    for (int i = 0; i < 4; i++) begin
      step0(b2b[i], 1'b1);
      exp0 = model(64'(b2b[i]), 4, 2, 1'b1, exp0);
      chk0($sformatf("b2b%0d", i), exp0.o, exp0.e[3:0], exp0.c[2:0], 1'b1);
    end

    // Randomized traffic on all three configurations
    for (int i = 0; i < 300; i++) begin
      vld = ($urandom_range(0, 3) != 0);
      w   = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
      if (vld) begin
        if0.in = w[7:0]; if1.in = w[0:0]; if2.in = w[14:0];
      end else begin
        if0.in = 'x; if1.in = 'x; if2.in = 'x;
      end
      if0.in_valid = vld; if1.in_valid = vld; if2.in_valid = vld;
      exp0 = model(w & 64'hFF,   4, 2, vld, exp0);
      exp1 = model(w & 64'h1,    1, 1, vld, exp1);
      exp2 = model(w & 64'h7FFF, 5, 3, vld, exp2);
      @(posedge clk);
      #1;
      chk0("rnd0", exp0.o, exp0.e[3:0], exp0.c[2:0], exp0.v);
      chk("rnd1.out",       32'(if1.out),       32'(exp1.o));
      chk("rnd1.elem_or",   32'(if1.elem_or),   32'(exp1.e[0]));
      chk("rnd1.nz_count",  32'(if1.nz_count),  32'(exp1.c[0]));
      chk("rnd1.out_valid", 32'(if1.out_valid), 32'(exp1.v));
      chk("rnd2.out",       32'(if2.out),       32'(exp2.o));
      chk("rnd2.elem_or",   32'(if2.elem_or),   32'(exp2.e[4:0]));
      chk("rnd2.nz_count",  32'(if2.nz_count),  32'(exp2.c[2:0]));
      chk("rnd2.out_valid", 32'(if2.out_valid), 32'(exp2.v));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
